// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the L1 data cache controller.
package dcache_pkg;
    localparam int ADDR_SIZE       = 32;
    localparam int BLOCK_SIZE_BITS = 128;
    localparam int BLOCK_BYTES_NUM = BLOCK_SIZE_BITS / 8;
    localparam int INDEX_BITS      = 6;
    localparam int OFFSET_BITS     = $clog2(BLOCK_BYTES_NUM);
    localparam int TAG_BITS        = ADDR_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int WORDS_NUM       = BLOCK_SIZE_BITS / 32;
    localparam int WORD_SEL_BITS   = OFFSET_BITS - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_FILL,
        ST_REISSUE
    } state_t;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_SIZE-1:0] a);
        return a[ADDR_SIZE-1 -: TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_index(input logic [ADDR_SIZE-1:0] a);
        return a[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [ADDR_SIZE-1:0] a);
        return a[2 +: WORD_SEL_BITS];
    endfunction

    function automatic logic [ADDR_SIZE-1:0] block_addr(input logic [TAG_BITS-1:0] tag,
                                                        input logic [INDEX_BITS-1:0] index);
        return {tag, index, {OFFSET_BITS{1'b0}}};
    endfunction

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == '1) ? c : c + 32'd1;
    endfunction
endpackage

// File: rtl/d_cache_ctrl_if.sv
// CPU-side request/response channel of the data cache; master = pipeline, slave = cache.
interface d_cache_ctrl_if;
    logic                              cpu_req_valid;
    logic                              cpu_req_ready;
    logic                              cpu_req_wen;
    logic [dcache_pkg::ADDR_SIZE-1:0]  cpu_req_addr;
    logic [31:0]                       cpu_req_wdata;
    logic [3:0]                        cpu_req_byteen;
    logic                              cpu_resp_valid;
    logic [31:0]                       cpu_resp_rdata;

    modport master (
        output cpu_req_valid, cpu_req_wen, cpu_req_addr, cpu_req_wdata, cpu_req_byteen,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
    );

    modport slave (
        input  cpu_req_valid, cpu_req_wen, cpu_req_addr, cpu_req_wdata, cpu_req_byteen,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata
    );
endinterface

// File: rtl/dcache_word_sel.sv
// Word-level view of a cache line: load word extraction, store byte-lane mask and replicated store data.
module dcache_word_sel
    import dcache_pkg::*;
(
    input  logic [WORD_SEL_BITS-1:0]   i_word,
    input  logic [BLOCK_SIZE_BITS-1:0] i_block,
    input  logic [31:0]                i_wdata,
    input  logic [3:0]                 i_byteen,
    output logic [31:0]                o_rdata,
    output logic [BLOCK_BYTES_NUM-1:0] o_bytes,
    output logic [BLOCK_SIZE_BITS-1:0] o_wblock
);
    logic [31:0] w_words [WORDS_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_NUM; gi++) begin : g_word
            assign w_words[gi]           = i_block[gi*32 +: 32];
            assign o_bytes[gi*4 +: 4]    = (int'(i_word) == gi) ? i_byteen : 4'b0000;
            assign o_wblock[gi*32 +: 32] = i_wdata;
        end
    endgenerate

    assign o_rdata = w_words[i_word];
endmodule

// File: rtl/d_cache_ctrl.sv
// L1 data cache sequencer: one CPU access at a time, D_SRAM lookup/write and block-wide memory writeback/refill.
module d_cache_ctrl
    import dcache_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    d_cache_ctrl_if.slave              cpu,
    output logic                       o_sram_en,
    output logic                       o_sram_wen,
    output logic                       o_sram_dmemWen,
    output logic [BLOCK_BYTES_NUM-1:0] o_sram_bytesAccess,
    output logic [ADDR_SIZE-1:0]       o_sram_addr,
    output logic [BLOCK_SIZE_BITS-1:0] o_sram_dataIn,
    input  logic                       i_sram_hit,
    input  logic                       i_sram_dirtyBit,
    input  logic [BLOCK_SIZE_BITS-1:0] i_sram_dataOut,
    input  logic [TAG_BITS-1:0]        i_sram_victimTag,
    output logic                       o_mem_req,
    output logic                       o_mem_wen,
    output logic [ADDR_SIZE-1:0]       o_mem_addr,
    output logic [BLOCK_SIZE_BITS-1:0] o_mem_wdata,
    input  logic                       i_mem_ack,
    input  logic [BLOCK_SIZE_BITS-1:0] i_mem_rdata,
    output logic [31:0]                o_hit_cnt,
    output logic [31:0]                o_miss_cnt,
    output logic [31:0]                o_wb_cnt
);
    state_t                     r_state;
    logic [ADDR_SIZE-1:0]       r_addr;
    logic                       r_wen;
    logic [31:0]                r_wdata;
    logic [3:0]                 r_byteen;
    logic [BLOCK_SIZE_BITS-1:0] r_victim_data;
    logic [TAG_BITS-1:0]        r_victim_tag;
    logic [BLOCK_SIZE_BITS-1:0] r_fill_data;
    logic                       r_replay;
    logic [31:0]                r_hit_cnt;
    logic [31:0]                r_miss_cnt;
    logic [31:0]                r_wb_cnt;

    logic [WORD_SEL_BITS-1:0]   w_word;
    logic [31:0]                w_load_word;
    logic [BLOCK_BYTES_NUM-1:0] w_lane_mask;
    logic [BLOCK_SIZE_BITS-1:0] w_store_block;
    logic                       w_live;

    assign w_word = addr_word(r_addr);
    assign w_live = !rst;

    dcache_word_sel u_word_sel (
        .i_word   (w_word),
        .i_block  (i_sram_dataOut),
        .i_wdata  (r_wdata),
        .i_byteen (r_byteen),
        .o_rdata  (w_load_word),
        .o_bytes  (w_lane_mask),
        .o_wblock (w_store_block)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_byteen      <= '0;
            r_victim_data <= '0;
            r_victim_tag  <= '0;
            r_fill_data   <= '0;
            r_replay      <= 1'b0;
            r_hit_cnt     <= '0;
            r_miss_cnt    <= '0;
            r_wb_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu.cpu_req_valid) begin
                        r_addr   <= cpu.cpu_req_addr;
                        r_wen    <= cpu.cpu_req_wen;
                        r_wdata  <= cpu.cpu_req_wdata;
                        r_byteen <= cpu.cpu_req_byteen;
                        r_replay <= 1'b0;
                        r_state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (i_sram_hit) begin
                        // The replay after a refill is the same access, already counted as a miss.
                        if (!r_replay) r_hit_cnt <= sat_inc(r_hit_cnt);
                        r_state <= ST_IDLE;
                    end else begin
                        r_miss_cnt <= sat_inc(r_miss_cnt);
                        if (i_sram_dirtyBit) begin
                            r_victim_data <= i_sram_dataOut;
                            r_victim_tag  <= i_sram_victimTag;
                            r_state       <= ST_WRITEBACK;
                        end else begin
                            r_state <= ST_REFILL;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (i_mem_ack) begin
                        r_wb_cnt <= sat_inc(r_wb_cnt);
                        r_state  <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ack) begin
                        r_fill_data <= i_mem_rdata;
                        r_state     <= ST_FILL;
                    end
                end
                ST_FILL: r_state <= ST_REISSUE;
                ST_REISSUE: begin
                    r_replay <= 1'b1;
                    r_state  <= ST_LOOKUP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are qualified by !rst so a reset cycle never writes the array or holds memory.
    always_comb begin
        cpu.cpu_req_ready   = 1'b0;
        cpu.cpu_resp_valid  = 1'b0;
        cpu.cpu_resp_rdata  = '0;
        o_sram_en           = 1'b0;
        o_sram_wen          = 1'b0;
        o_sram_dmemWen      = 1'b0;
        o_sram_bytesAccess  = '0;
        o_sram_addr         = '0;
        o_sram_dataIn       = '0;
        o_mem_req           = 1'b0;
        o_mem_wen           = 1'b0;
        o_mem_addr          = '0;
        o_mem_wdata         = '0;
        case (r_state)
            ST_IDLE: begin
                cpu.cpu_req_ready = 1'b1;
                if (cpu.cpu_req_valid && w_live) begin
                    o_sram_en   = 1'b1;
                    o_sram_addr = cpu.cpu_req_addr;
                end
            end
            ST_LOOKUP: begin
                o_sram_addr = r_addr;
                if (i_sram_hit && w_live) begin
                    cpu.cpu_resp_valid = 1'b1;
                    cpu.cpu_resp_rdata = w_load_word;
                    if (r_wen) begin
                        o_sram_en          = 1'b1;
                        o_sram_wen         = 1'b1;
                        o_sram_bytesAccess = w_lane_mask;
                        o_sram_dataIn      = w_store_block;
                    end
                end
            end
            ST_WRITEBACK: begin
                o_mem_req   = w_live;
                o_mem_wen   = w_live;
                o_mem_addr  = block_addr(r_victim_tag, addr_index(r_addr));
                o_mem_wdata = r_victim_data;
            end
            ST_REFILL: begin
                o_mem_req  = w_live;
                o_mem_addr = block_addr(addr_tag(r_addr), addr_index(r_addr));
            end
            ST_FILL: begin
                o_sram_en          = w_live;
                o_sram_wen         = w_live;
                o_sram_dmemWen     = w_live;
                o_sram_bytesAccess = '1;
                o_sram_addr        = r_addr;
                o_sram_dataIn      = r_fill_data;
            end
            ST_REISSUE: begin
                o_sram_en   = w_live;
                o_sram_addr = r_addr;
            end
            default: ;
        endcase
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
    assign o_wb_cnt   = r_wb_cnt;
endmodule

// File: doc/d_cache_ctrl.md
# d_cache_ctrl

Sequencing FSM for the L1 data cache: accepts one CPU load/store at a time and drives the `D_SRAM` array (lookup, store-hit write, refill write). It also drives the block-wide main-memory port for dirty-victim writeback and line refill. It sits between the MEM pipeline stage and `D_SRAM` / data memory. It keeps saturating hit/miss/writeback counters for performance reporting.

## Interface
- `ADDR_SIZE`, 32, byte address width
- `BLOCK_SIZE_BITS`, 128, cache line width (`BLOCK_BYTES_NUM` = `BLOCK_SIZE_BITS`/8 = 16)
- `INDEX_BITS`, 6, set index width; `OFFSET_BITS` = log2(`BLOCK_BYTES_NUM`); `TAG_BITS` = `ADDR_SIZE` − `INDEX_BITS` − `OFFSET_BITS`
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `cpu_req_valid` in 1, `cpu_req_ready` out 1: request handshake
- `cpu_req_wen` in 1: 1 = store
- `cpu_req_addr` in `ADDR_SIZE`: byte address
- `cpu_req_wdata` in 32, `cpu_req_byteen` in 4: store data and byte lanes (word-aligned)
- `cpu_resp_valid` out 1, `cpu_resp_rdata` out 32: one-cycle completion pulse, load word
- `sram_en`, `sram_wen`, `sram_dmemWen` out 1: D_SRAM strobes
- `sram_bytesAccess` out `BLOCK_BYTES_NUM`, `sram_addr` out `ADDR_SIZE`, `sram_dataIn` out `BLOCK_SIZE_BITS`
- `sram_hit`, `sram_dirtyBit` in 1, `sram_dataOut` in `BLOCK_SIZE_BITS`, `sram_victimTag` in `TAG_BITS`: lookup result, valid the cycle after a read
- `mem_req`, `mem_wen` out 1, `mem_addr` out `ADDR_SIZE` (block-aligned), `mem_wdata` out `BLOCK_SIZE_BITS`
- `mem_ack` in 1, `mem_rdata` in `BLOCK_SIZE_BITS`
- `hit_cnt`, `miss_cnt`, `wb_cnt` out 32: saturating event counters

## Operation
- D_SRAM contract:
  - `en`&!`wen`: read.
  - `en`&`wen`&!`dmemWen`: CPU write of enabled bytes, sets dirty.
  - `en`&`wen`&`dmemWen`: refill write, sets valid, clears dirty, installs tag from `sram_addr`.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, FILL, REISSUE.
- IDLE
  - `cpu_req_ready`=1.
  - On valid&ready: latch addr/wen/wdata/byteen, drive SRAM read of `cpu_req_addr`, go to LOOKUP.
- LOOKUP: sample SRAM outputs.
  - Hit load: `cpu_resp_valid`=1, rdata = `sram_dataOut` word at `addr[OFFSET_BITS-1:2]` → IDLE.
  - Hit store: SRAM CPU write. `sram_bytesAccess` = byteen shifted to word lane. `sram_dataIn` = wdata replicated across all words. `cpu_resp_valid`=1 → IDLE.
  - Miss with dirty: latch `sram_dataOut` and `sram_victimTag` → WRITEBACK.
  - Miss clean → REFILL.
  - Counters: hit_cnt increments on hits, except the hit in the replay LOOKUP after REISSUE. miss_cnt increments on misses.
- WRITEBACK
  - Hold `mem_req`=1, `mem_wen`=1, `mem_addr`={victimTag, index, 0}, `mem_wdata`=victim.
  - On `mem_ack`: wb_cnt++ → REFILL.
- REFILL
  - Hold `mem_req`=1, `mem_wen`=0, `mem_addr`={req tag, index, 0}.
  - On `mem_ack`: latch `mem_rdata` → FILL.
- FILL: one cycle of SRAM refill write, `sram_bytesAccess` all ones → REISSUE.
- REISSUE: SRAM read of the latched address → LOOKUP. The replay LOOKUP always hits and completes as above.
- Counters saturate at 0xFFFF_FFFF and hold.

## Timing
- Reset values:
  - state = IDLE.
  - `cpu_req_ready`=1.
  - `cpu_resp_valid`, `sram_en`, `sram_wen`, `sram_dmemWen`, `mem_req`, `mem_wen` = 0.
  - All buses and counters = 0.
- Hit latency: accept at edge N, `cpu_resp_valid` high during cycle N+1.
- Clean miss: 5 cycles + memory ack latency (accept, LOOKUP, REFILL, FILL, REISSUE, LOOKUP). Dirty miss adds WRITEBACK plus its ack latency.
- All SRAM and memory outputs are combinational from state and latched request. `mem_*` outputs are stable while `mem_req`=1.
- `mem_ack` is a single-cycle pulse. It is ignored outside WRITEBACK/REFILL. An ack in the same cycle `mem_req` rises is valid (zero-wait memory).
- `cpu_req_ready`=0 in every state but IDLE. `cpu_req_valid` while busy is not accepted and must be held by the requester.
- A new request may be accepted in the cycle after `cpu_resp_valid`; there is no back-to-back accept in the same cycle.
- `rst` mid-transaction: next state IDLE and `mem_req` drops. The memory model abandons the request, and no SRAM write occurs in the reset cycle.

## Structure
- Shared package `dcache_pkg`:
  - state enum;
  - `ADDR_SIZE`, `BLOCK_SIZE_BITS`, `BLOCK_BYTES_NUM`, `INDEX_BITS`, `OFFSET_BITS`, `TAG_BITS`;
  - address field slice helpers.
- One sub-module, `dcache_word_sel`: selects the load word and generates the byte-lane mask and replicated store data from the offset.

## Test plan
- Cold load 0x0000_0104, memory returns line 0x…DDDD_CCCC_BBBB_AAAA:
  - required: no WRITEBACK; REFILL addr 0x0000_0100; rdata 0xBBBB_BBBB (word 1);
  - miss_cnt=1, hit_cnt=0.
- Repeat load 0x104: `cpu_resp_valid` one cycle after accept, same data, hit_cnt=1.
- Store 0x104 with wdata 0x1234_5678, byteen 0011:
  - required: `sram_bytesAccess`=0x0030;
  - a following load returns 0xBBBB_5678.
- Load to 0x0000_1104 (same index, new tag):
  - required: WRITEBACK addr 0x0000_0100 with the dirty line first, then REFILL 0x0000_1100;
  - wb_cnt=1.
- Assert `rst` while in REFILL with `mem_ack` never sent:
  - required: next cycle IDLE, `mem_req`=0, `cpu_req_ready`=1, counters 0.
- Hold `cpu_req_valid` with a second request during a miss: it is not accepted until the cycle after the first `cpu_resp_valid`, then completes correctly.
